// File: rtl/meas_pkg.sv
// meas_pkg: shared types and constants for the measurement sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package meas_pkg;

    localparam int CW_DEFAULT = 24;

    localparam logic CH_ADC = 1'b0;
    localparam logic CH_CAP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SWITCH  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_MEASURE = 3'd4,
        ST_FLUSH   = 3'd5,
        ST_LATCH   = 3'd6
    } state_e;

endpackage

// File: rtl/meas_frame_timer.sv
// meas_frame_timer: loadable down-counter of frame_tick pulses; done marks the tick that reaches zero.
// Latency: done is combinational on the final tick; the count updates one clk later.
// Backpressure: none; ticks with tick low are simply not counted.
module meas_frame_timer #(
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          async_reset,
    input  logic          load,
    input  logic [FW-1:0] load_val,
    input  logic          tick,
    output logic          done
);

    logic [FW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        done  = tick && (cnt_q == FW'(1));
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/meas_sequencer.sv
// meas_sequencer: time-slices the shared pulse counter between ADC and capacitance channels; MEAS_SEQ_TIMEOUT_EN adds a frame-tick watchdog.
// Latency: result_valid rises LATCH_DELAY+2 clk after the last window tick.
// Backpressure: nothing stalls the sequencer; an unacked result is overwritten and flagged in result_overrun.
module meas_sequencer
    import meas_pkg::*;
#(
    parameter int CW             = CW_DEFAULT,
    parameter int WINDOW_FRAMES  = 200,
    parameter int SETTLE_FRAMES  = 2,
    parameter int LATCH_DELAY    = 2,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic          clk,
    input  logic          async_reset,
    input  logic          frame_tick,
    input  logic [1:0]    ch_en,
    output logic          cnt_sel,
    output logic          cnt_clear,
    output logic          cnt_gate,
    input  logic [CW-1:0] count_p,
    input  logic [CW-1:0] count_m,
    output logic [CW-1:0] result_p,
    output logic [CW-1:0] result_m,
    output logic [CW:0]   result_diff,
    output logic          result_ch,
    output logic          result_valid,
    input  logic          result_ack,
    output logic          result_overrun,
    output logic          busy
`ifdef MEAS_SEQ_TIMEOUT_EN
    ,
    output logic          meas_timeout
`endif
);

    localparam int FMAX = (WINDOW_FRAMES > SETTLE_FRAMES) ? WINDOW_FRAMES : SETTLE_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int DW   = (LATCH_DELAY > 1) ? $clog2(LATCH_DELAY) : 1;

    state_e        state_q, state_d;
    logic          chan_q, chan_d;
    logic          pref_q, pref_d;
    logic          sel_q, sel_d;
    logic          gate_q, gate_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [CW-1:0] res_p_q, res_p_d;
    logic [CW-1:0] res_m_q, res_m_d;
    logic [CW:0]   diff_q, diff_d;
    logic          res_ch_q, res_ch_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic          tmr_load;
    logic [FW-1:0] tmr_val;
    logic          tmr_tick;
    logic          tmr_done;
    logic          pick_ch;
    logic          abort;

`ifdef MEAS_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           to_q, to_d;
`endif

    meas_frame_timer #(
        .FW(FW)
    ) u_frame_timer (
        .clk        (clk),
        .async_reset(async_reset),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .tick       (tmr_tick),
        .done       (tmr_done)
    );

    // Preferred channel is the one not measured last; fall back to the other.
    assign pick_ch = ch_en[pref_q] ? pref_q : ~pref_q;
    assign abort   = ~ch_en[chan_q];

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        pref_d   = pref_q;
        sel_d    = sel_q;
        gate_d   = gate_q;
        dly_d    = dly_q;
        res_p_d  = res_p_q;
        res_m_d  = res_m_q;
        diff_d   = diff_q;
        res_ch_d = res_ch_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_tick = 1'b0;

        if (valid_q && result_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ch_en != 2'b00) begin
                    chan_d  = pick_ch;
                    pref_d  = ~pick_ch;
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                sel_d = chan_q;
                if (sel_q != chan_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = FW'(SETTLE_FRAMES);
                    state_d  = ST_SETTLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_SETTLE: begin
                tmr_tick = frame_tick;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = abort ? ST_IDLE : ST_MEASURE;
            end
            ST_MEASURE: begin
                // The window opens on the first tick, so gate time is tick-to-tick exact.
                if (abort) begin
                    gate_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (!gate_q) begin
                    if (frame_tick) begin
                        gate_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = FW'(WINDOW_FRAMES);
                    end
                end else begin
                    tmr_tick = frame_tick;
                    if (tmr_done) begin
                        gate_d  = 1'b0;
                        dly_d   = '0;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (dly_q == DW'(LATCH_DELAY - 1)) begin
                    state_d = ST_LATCH;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_LATCH: begin
                res_p_d  = count_p;
                res_m_d  = count_m;
                diff_d   = {1'b0, count_p} - {1'b0, count_m};
                res_ch_d = chan_q;
                valid_d  = 1'b1;
                if (valid_q && !result_ack) begin
                    ovr_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                gate_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef MEAS_SEQ_TIMEOUT_EN
    always_comb begin
        wd_d = '0;
        to_d = to_q;
        if (state_q == ST_LATCH) begin
            to_d = 1'b0;
        end
        if (((state_q == ST_SETTLE) || (state_q == ST_MEASURE)) && !frame_tick) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Overrides the main FSM when the frame tick has been silent too long.
    logic wd_fire;
    assign wd_fire = ((state_q == ST_SETTLE) || (state_q == ST_MEASURE)) && !frame_tick
                     && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_fire ? '0 : wd_d;
            to_q <= wd_fire ? 1'b1 : to_d;
        end
    end

    assign meas_timeout = to_q;
`endif

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q  <= ST_IDLE;
            chan_q   <= CH_ADC;
            pref_q   <= CH_ADC;
            sel_q    <= CH_ADC;
            gate_q   <= 1'b0;
            dly_q    <= '0;
            res_p_q  <= '0;
            res_m_q  <= '0;
            diff_q   <= '0;
            res_ch_q <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
`ifdef MEAS_SEQ_TIMEOUT_EN
            state_q <= wd_fire ? ST_IDLE : state_d;
            gate_q  <= wd_fire ? 1'b0 : gate_d;
`else
            state_q <= state_d;
            gate_q  <= gate_d;
`endif
            chan_q   <= chan_d;
            pref_q   <= pref_d;
            sel_q    <= sel_d;
            dly_q    <= dly_d;
            res_p_q  <= res_p_d;
            res_m_q  <= res_m_d;
            diff_q   <= diff_d;
            res_ch_q <= res_ch_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign cnt_sel        = sel_q;
    assign cnt_clear      = (state_q == ST_CLEAR);
    assign cnt_gate       = gate_q;
    assign result_p       = res_p_q;
    assign result_m       = res_m_q;
    assign result_diff    = diff_q;
    assign result_ch      = res_ch_q;
    assign result_valid   = valid_q;
    assign result_overrun = ovr_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer with a 4-frame window, 1 settle frame and a tick every 20 clk.
module tb_meas_sequencer;

    localparam int CW = 24;

    logic          clk;
    logic          async_reset;
    logic          frame_tick;
    logic [1:0]    ch_en;
    logic          cnt_sel, cnt_clear, cnt_gate;
    logic [CW-1:0] count_p, count_m, result_p, result_m;
    logic [CW:0]   result_diff;
    logic          result_ch, result_valid, result_ack, result_overrun, busy;
`ifdef MEAS_SEQ_TIMEOUT_EN
    logic          meas_timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit tick_en;
    int tick_cnt;

    meas_sequencer #(
        .CW(CW), .WINDOW_FRAMES(4), .SETTLE_FRAMES(1), .LATCH_DELAY(2), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .async_reset(async_reset), .frame_tick(frame_tick), .ch_en(ch_en),
        .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_gate(cnt_gate),
        .count_p(count_p), .count_m(count_m), .result_p(result_p), .result_m(result_m),
        .result_diff(result_diff), .result_ch(result_ch), .result_valid(result_valid),
        .result_ack(result_ack), .result_overrun(result_overrun), .busy(busy)
`ifdef MEAS_SEQ_TIMEOUT_EN
        , .meas_timeout(meas_timeout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        frame_tick = 1'b0;
        tick_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt   = (tick_cnt == 19) ? 0 : tick_cnt + 1;
            frame_tick = tick_en && (tick_cnt == 19);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        async_reset = 1'b1;
        ch_en       = 2'b00;
        result_ack  = 1'b0;
        tick_en     = 1'b1;
        repeat (3) @(negedge clk);
        async_reset = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_gate(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (cnt_gate) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        async_reset = 1'b1;
        ch_en = 2'b11;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (cnt_gate !== 1'b0) begin n_bad++; $display("FAIL reset_gate got=%b exp=0", cnt_gate); end
        n_cmp++; if (cnt_sel !== 1'b0) begin n_bad++; $display("FAIL reset_sel got=%b exp=0", cnt_sel); end
        n_cmp++; if (cnt_clear !== 1'b0) begin n_bad++; $display("FAIL reset_clear got=%b exp=0", cnt_clear); end
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        n_cmp++; if (result_diff !== '0) begin n_bad++; $display("FAIL reset_diff got=%h exp=0", result_diff); end
        async_reset = 1'b0;
        ch_en = 2'b00;
    endtask

    task automatic test_single_window();
        int  clears, gate_cyc, fall_at, rise_at;
        bit  prev_gate;
        do_reset();
        count_p = 24'd1000; count_m = 24'd400;
        ch_en = 2'b01;
        clears = 0; gate_cyc = 0; fall_at = -1; rise_at = -1; prev_gate = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (cnt_clear) clears++;
            if (cnt_gate) gate_cyc++;
            if (prev_gate && !cnt_gate && fall_at < 0) fall_at = c;
            prev_gate = cnt_gate;
            if (result_valid) begin
                rise_at = c;
                ch_en = 2'b00;
                break;
            end
        end
        n_cmp++; if (rise_at < 0) begin n_bad++; $display("FAIL single_timeout no result_valid within 600 clk"); end
        n_cmp++; if (clears != 1) begin n_bad++; $display("FAIL single_clears got=%0d exp=1", clears); end
        n_cmp++; if (gate_cyc != 80) begin n_bad++; $display("FAIL single_gate_len got=%0d exp=80", gate_cyc); end
        n_cmp++; if ((rise_at - fall_at) < 3 || (rise_at - fall_at) > 4) begin
            n_bad++; $display("FAIL single_latency got=%0d exp=3..4", rise_at - fall_at); end
        n_cmp++; if (result_diff !== 25'd600) begin n_bad++; $display("FAIL single_diff got=%0d exp=600", result_diff); end
        n_cmp++; if (result_ch !== 1'b0) begin n_bad++; $display("FAIL single_ch got=%b exp=0", result_ch); end
        n_cmp++; if (result_p !== 24'd1000 || result_m !== 24'd400) begin
            n_bad++; $display("FAIL single_pm got=%0d/%0d exp=1000/400", result_p, result_m); end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL single_ack got=%b exp=0", result_valid); end
    endtask

    task automatic test_round_robin();
        int       got, sw, tk, clears;
        bit       pend;
        logic     prev_sel;
        logic [3:0] chs;
        do_reset();
        count_p = 24'd100; count_m = 24'd50;
        ch_en = 2'b11;
        got = 0; sw = 0; tk = 0; clears = 0; pend = 1'b0; prev_sel = 1'b0; chs = '0;
        for (int c = 0; c < 1500 && got < 4; c++) begin
            @(negedge clk);
            result_ack = 1'b0;
            if (cnt_sel !== prev_sel) begin pend = 1'b1; tk = 0; end
            prev_sel = cnt_sel;
            if (pend && frame_tick) tk++;
            if (cnt_clear) begin
                clears++;
                if (pend) begin
                    sw++;
                    n_cmp++; if (tk != 1) begin n_bad++; $display("FAIL rr_settle_frames got=%0d exp=1", tk); end
                    pend = 1'b0;
                end
            end
            if (result_valid) begin
                chs[got] = result_ch;
                got++;
                result_ack = 1'b1;
                if (got == 4) ch_en = 2'b00;
            end
        end
        @(negedge clk);
        result_ack = 1'b0;
        n_cmp++; if (got != 4) begin n_bad++; $display("FAIL rr_results got=%0d exp=4", got); end
        n_cmp++; if (chs !== 4'b1010) begin n_bad++; $display("FAIL rr_channels got=%b exp=1010 (ch3..ch0)", chs); end
        n_cmp++; if (sw != 3) begin n_bad++; $display("FAIL rr_switches got=%0d exp=3", sw); end
        n_cmp++; if (clears != 4) begin n_bad++; $display("FAIL rr_clears got=%0d exp=4", clears); end
    endtask

    task automatic test_negative_diff();
        bit ok;
        do_reset();
        count_p = 24'd5; count_m = 24'd9;
        ch_en = 2'b01;
        wait_valid(400, ok);
        ch_en = 2'b00;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL neg_timeout no result_valid within 400 clk"); end
        n_cmp++; if (result_diff !== 25'h1FFFFFC) begin n_bad++; $display("FAIL neg_diff got=%h exp=1fffffc", result_diff); end
    endtask

    task automatic test_overrun();
        bit ok;
        bit found;
        do_reset();
        count_p = 24'd11; count_m = 24'd1;
        ch_en = 2'b01;
        wait_valid(400, ok);
        count_p = 24'd22;
        n_cmp++; if (!ok || result_overrun !== 1'b0) begin
            n_bad++; $display("FAIL ovr_first got valid=%b ovr=%b exp valid=1 ovr=0", ok, result_overrun); end
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (result_p === 24'd22) begin found = 1'b1; ch_en = 2'b00; break; end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL ovr_second_timeout no second result within 400 clk"); end
        n_cmp++; if (result_overrun !== 1'b1 || result_valid !== 1'b1) begin
            n_bad++; $display("FAIL ovr_flag got ovr=%b valid=%b exp 1/1", result_overrun, result_valid); end
        n_cmp++; if (result_diff !== 25'd21) begin n_bad++; $display("FAIL ovr_diff got=%0d exp=21", result_diff); end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        n_cmp++; if (result_valid !== 1'b0 || result_overrun !== 1'b0) begin
            n_bad++; $display("FAIL ovr_ack_clear got valid=%b ovr=%b exp 0/0", result_valid, result_overrun); end
    endtask

    task automatic test_ack_at_latch();
        bit ok;
        bit fell;
        bit prev_gate;
        do_reset();
        count_p = 24'd30; count_m = 24'd10;
        ch_en = 2'b01;
        wait_valid(400, ok);
        count_p = 24'd50;
        fell = 1'b0; prev_gate = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (prev_gate && !cnt_gate) begin fell = 1'b1; break; end
            prev_gate = cnt_gate;
        end
        @(negedge clk);
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        ch_en = 2'b00;
        n_cmp++; if (!ok || !fell) begin n_bad++; $display("FAIL same_ack_timeout got valid=%b fall=%b exp 1/1", ok, fell); end
        n_cmp++; if (result_valid !== 1'b1 || result_overrun !== 1'b0) begin
            n_bad++; $display("FAIL same_ack_flags got valid=%b ovr=%b exp 1/0", result_valid, result_overrun); end
        n_cmp++; if (result_diff !== 25'd40) begin n_bad++; $display("FAIL same_ack_diff got=%0d exp=40", result_diff); end
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        count_p = 24'd77; count_m = 24'd7;
        ch_en = 2'b01;
        wait_gate(200, ok);
        repeat (30) @(negedge clk);
        ch_en = 2'b00;
        @(negedge clk);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_timeout gate never rose within 200 clk"); end
        n_cmp++; if (cnt_gate !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_stop got gate=%b busy=%b exp 0/0", cnt_gate, busy); end
        repeat (150) @(negedge clk);
        n_cmp++; if (result_valid !== 1'b0 || result_p !== '0) begin
            n_bad++; $display("FAIL abort_no_result got valid=%b p=%0d exp 0/0", result_valid, result_p); end
    endtask

    task automatic test_async_reset_mid();
        bit ok, ok2;
        do_reset();
        count_p = 24'd7; count_m = 24'd3;
        ch_en = 2'b10;
        wait_valid(400, ok);
        n_cmp++; if (!ok || result_ch !== 1'b1 || cnt_sel !== 1'b1) begin
            n_bad++; $display("FAIL arst_setup got valid=%b ch=%b sel=%b exp 1/1/1", ok, result_ch, cnt_sel); end
        wait_gate(200, ok2);
        repeat (10) @(negedge clk);
        #2;
        async_reset = 1'b1;
        #1;
        n_cmp++; if (!ok2 || cnt_gate !== 1'b0 || cnt_sel !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL arst_ctrl got gate_seen=%b gate=%b sel=%b busy=%b exp 1/0/0/0", ok2, cnt_gate, cnt_sel, busy); end
        n_cmp++; if (result_valid !== 1'b0 || result_p !== '0 || result_diff !== '0 || result_ch !== 1'b0) begin
            n_bad++; $display("FAIL arst_result got valid=%b p=%0d diff=%0d ch=%b exp all 0", result_valid, result_p, result_diff, result_ch); end
        ch_en = 2'b00;
        @(negedge clk);
        async_reset = 1'b0;
    endtask

`ifdef MEAS_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, seen_tick, fired;
        int n;
        do_reset();
        ch_en = 2'b01;
        wait_gate(200, ok);
        seen_tick = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_tick) begin seen_tick = 1'b1; break; end
        end
        tick_en = 1'b0;
        n = 0; fired = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n++;
            if (meas_timeout) begin fired = 1'b1; break; end
        end
        n_cmp++; if (!ok || !seen_tick || !fired) begin
            n_bad++; $display("FAIL to_timeout got gate=%b tick=%b fired=%b exp 1/1/1", ok, seen_tick, fired); end
        n_cmp++; if (n < 50 || n > 51) begin n_bad++; $display("FAIL to_cycles got=%0d exp=50..51", n); end
        n_cmp++; if (cnt_gate !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL to_state got gate=%b busy=%b exp 0/0", cnt_gate, busy); end
        ch_en = 2'b00;
        tick_en = 1'b1;
    endtask
`endif

    initial begin
        async_reset = 1'b1;
        ch_en       = 2'b00;
        result_ack  = 1'b0;
        count_p     = '0;
        count_m     = '0;
        tick_en     = 1'b1;
        test_reset();
        test_single_window();
        test_round_robin();
        test_negative_diff();
        test_overrun();
        test_ack_at_latch();
        test_abort();
        test_async_reset_mid();
`ifdef MEAS_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
- Schedules the shared pulse counter between two measurement sources: channel 0 (sigma-delta ADC trigger) and channel 1 (capacitance comparator, gated by antibounce).
- Drives the source-select, clear and gate controls of the counter.
- Times a measurement window in 5 ms frame ticks and latches the counter's p/m totals.
- Presents one result per window to the host-interface side through a valid/ack handshake.

Parameters:
- CW, 24: counter / result width.
- WINDOW_FRAMES, 200: frame ticks per measurement window (1 s at 5 ms).
- SETTLE_FRAMES, 2: frame ticks discarded after a source switch.
- LATCH_DELAY, 2: clk cycles between gate fall and result capture, for counter pipeline flush.
- TIMEOUT_CYCLES, 120000: watchdog limit on clk cycles between frame ticks (optional feature only).

Ports:
- clk  in  1  system clock, 12 MHz.
- async_reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per 5 ms frame, already synchronous to clk.
- ch_en  in  2  per-channel measurement request; bit0 = ADC, bit1 = capacitance.
- cnt_sel  out  1  counter source select; 0 = ADC, 1 = capacitance.
- cnt_clear  out  1  one-cycle counter clear pulse.
- cnt_gate  out  1  counting enable, high only during the window.
- count_p  in  CW  counter positive total.
- count_m  in  CW  counter negative total.
- result_p  out  CW  latched count_p.
- result_m  out  CW  latched count_m.
- result_diff  out  CW+1  signed result_p − result_m.
- result_ch  out  1  channel of the latched result.
- result_valid  out  1  result available.
- result_ack  in  1  one-cycle consumer acknowledge.
- result_overrun  out  1  sticky: an unacked result was overwritten.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; current channel 0.
- States: IDLE, SWITCH, SETTLE, CLEAR, MEASURE, FLUSH, LATCH.
- IDLE:
  - If ch_en == 00, stay in IDLE.
  - Otherwise pick the next channel round-robin: the channel other than the last one measured, if its bit is set; else the same channel. First pick after reset is ch0 if enabled.
  - Go to SWITCH.
- SWITCH (1 cycle): cnt_sel <= chosen channel.
  - If cnt_sel changed: go to SETTLE.
  - Else: go to CLEAR.
- SETTLE: count frame_tick; after SETTLE_FRAMES ticks go to CLEAR.
- CLEAR (1 cycle): cnt_clear = 1, then go to MEASURE.
- MEASURE:
  - cnt_gate = 1; count frame_tick.
  - On the WINDOW_FRAMES-th tick, cnt_gate drops the next cycle and the state goes to FLUSH.
  - Window length in clk cycles is exact frame multiples, measured tick-to-tick. The window opens at the first tick after CLEAR.
- FLUSH: wait LATCH_DELAY cycles, then go to LATCH.
- LATCH (1 cycle):
  - Capture result_p, result_m, result_ch.
  - result_diff = sign-extended count_p − count_m, registered the same cycle.
  - Set result_valid = 1, then go to IDLE.
- Handshake:
  - result_valid stays high until a cycle with result_ack = 1, then clears the next cycle.
  - result_ack while result_valid = 0 is ignored.
- Overrun:
  - LATCH while result_valid = 1 and no ack that cycle: overwrite the result and set result_overrun.
  - LATCH and ack in the same cycle: new result stored, result_valid stays 1, no overrun.
  - result_overrun clears on the next accepted ack.
- Abort: if the active channel's ch_en bit drops in SETTLE, CLEAR or MEASURE:
  - cnt_gate = 0 next cycle; go to IDLE.
  - No LATCH; result registers unchanged.
- Frame counter:
  - Reaches WINDOW_FRAMES ≤ 2^16−1, width from $clog2.
  - Never wraps: it reloads on every state entry.
- frame_tick during SWITCH, CLEAR or FLUSH is ignored.
- async_reset mid-operation: immediate return to reset values, including cnt_gate = 0.

Optional Feature:
- Macro MEAS_SEQ_TIMEOUT_EN.
- With the macro:
  - A watchdog counts clk cycles since the last frame_tick while in SETTLE or MEASURE.
  - Reaching TIMEOUT_CYCLES forces cnt_gate = 0, returns to IDLE and sets output meas_timeout (1 bit, sticky).
  - meas_timeout clears on the next successful LATCH.
- Without the macro:
  - No watchdog logic.
  - meas_timeout port absent.
  - A stalled frame_tick holds the state indefinitely.

Decomposition:
- Package meas_pkg:
  - State enum type.
  - Channel constants CH_ADC = 0, CH_CAP = 1.
  - Default CW.
- One sub-module, meas_frame_timer: loadable down-counter of frame_tick pulses with a done flag, instanced once and reused by SETTLE and MEASURE.

Test Plan (WINDOW_FRAMES = 4, SETTLE_FRAMES = 1, LATCH_DELAY = 2, 5 ms tick replaced by a pulse every 20 clk):
- ch_en = 01, counter model fixed at count_p = 1000, count_m = 400:
  - cnt_clear pulses once; cnt_gate high for exactly 80 clk.
  - result_valid rises 3–4 clk after gate fall.
  - result_diff = 600, result_ch = 0.
- ch_en = 11, ack every result: result_ch sequence 0,1,0,1; each switch inserts one settle frame (20 clk) before cnt_clear.
- count_p = 5, count_m = 9: result_diff = −4 (25-bit 0x1FFFFFC).
- Never ack, two windows complete: second result overwrites first; result_overrun = 1; one ack clears both result_valid and result_overrun.
- Drop ch_en[0] mid-MEASURE: cnt_gate low next cycle, busy low, result_valid stays 0. Also assert async_reset mid-window: all outputs 0 immediately.
- With MEAS_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 50, stop ticks during MEASURE: meas_timeout = 1 at cycle 50, gate low, state IDLE.
